// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared encodings and entry layout for the store buffer
//
// Purpose : store size encodings, byte-strobe patterns and the packed
//           store entry type shared by the buffer and the lane aligner.
// Ports   : none (package)

package store_pkg;

  localparam logic [1:0] STORE_SIZE_BYTE = 2'd0;
  localparam logic [1:0] STORE_SIZE_HALF = 2'd1;
  localparam logic [1:0] STORE_SIZE_WORD = 2'd2;

  // Strobe patterns for lane 0; byte and half patterns are shifted into place.
  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] val;
    logic [1:0]  size;
  } store_entry_t;

  // Two addresses touch the same memory word when their word indices match.
  function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - data-memory write port between store buffer and memory
//
// Purpose : groups the req/ack write handshake and its payload.
// Ports   : mem_req   - write presented (store buffer -> memory)
//           mem_addr  - word-aligned byte address
//           mem_wdata - lane-replicated write data
//           mem_wstrb - byte enables
//           mem_ack   - write accepted (memory -> store buffer)
// Modports: master = store buffer side, slave = memory side.

interface store_buffer_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ack
  );

endinterface

// File: rtl/store_lane_align.sv
// rtl/store_lane_align.sv - places right-aligned store data onto byte lanes
//
// Purpose : combinational strobe/data generation for a 32-bit write port.
// Ports   : addr_lo[1:0] - low address bits selecting the lane
//           size[1:0]    - store size encoding (byte/half/word, 3 reserved)
//           val[31:0]    - right-aligned store data
//           wdata[31:0]  - data replicated across all lanes
//           wstrb[3:0]   - byte enables for the addressed lanes

module store_lane_align
  import store_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] val,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb
);

  // Data is replicated rather than shifted so the strobes alone pick the lanes.
  always_comb begin
    wstrb = STRB_NONE;
    wdata = val;
    case (size)
      STORE_SIZE_BYTE: begin
        wstrb = STRB_BYTE << addr_lo;
        wdata = {4{val[7:0]}};
      end
      STORE_SIZE_HALF: begin
        // addr_lo[0] is ignored: misaligned halves never reach this point.
        wstrb = STRB_HALF << {addr_lo[1], 1'b0};
        wdata = {2{val[15:0]}};
      end
      STORE_SIZE_WORD: begin
        wstrb = STRB_WORD;
        wdata = val;
      end
      default: begin
        // Reserved size: no lanes enabled, entry still drains.
        wstrb = STRB_NONE;
        wdata = val;
      end
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - FIFO of committed stores draining to the data-memory port
//
// Purpose : buffers committed stores, drains the head entry through a
//           req/ack write port, flags loads that hit a pending store word.
// Ports   : clk             - system clock
//           reset           - asynchronous active-low reset
//           store_addr/val/size, store_push - enqueue request from execute
//           storefifo_full  - backpressure to execute (count == DEPTH)
//           empty           - nothing pending
//           mem             - write port (store_buffer_if.master)
//           load_check_addr - address of an in-flight load
//           load_conflict   - a pending store covers the same 32-bit word
// DEPTH must be a power of two and at least 2 so pointers wrap naturally.

module store_buffer
  import store_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          store_addr,
  input  logic [31:0]          store_val,
  input  logic [1:0]           store_size,
  input  logic                 store_push,
  output logic                 storefifo_full,
  output logic                 empty,
  store_buffer_if.master       mem,
  input  logic [31:0]          load_check_addr,
  output logic                 load_conflict
);

  localparam int PW = $clog2(DEPTH);

  store_entry_t  entries [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic          push_ok;
  logic          pop;
  store_entry_t  head_entry;

  assign storefifo_full = (count == (PW+1)'(DEPTH));
  assign empty          = (count == '0);

  // A full buffer rejects pushes even when the head pops in the same cycle.
  assign push_ok = store_push && !storefifo_full;
  assign pop     = mem.mem_req && mem.mem_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + 1'b1;
      if (pop)     head <= head + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload needs no reset: validity is tracked purely by head/count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      entries[tail] <= store_entry_t'{addr: store_addr, val: store_val, size: store_size};
    end
  end

  assign head_entry   = entries[head];
  assign mem.mem_req  = !empty;
  assign mem.mem_addr = {head_entry.addr[31:2], 2'b00};

  store_lane_align u_lane_align (
    .addr_lo (head_entry.addr[1:0]),
    .size    (head_entry.size),
    .val     (head_entry.val),
    .wdata   (mem.mem_wdata),
    .wstrb   (mem.mem_wstrb)
  );

  // Slot i is live when its distance past head is below count; this also
  // covers the head entry while its write is still outstanding.
  always_comb begin
    load_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PW'(PW'(i) - head)} < count) &&
          same_word(entries[i].addr, load_check_addr)) begin
        load_conflict = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer

module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] store_addr;
  logic [31:0] store_val;
  logic [1:0]  store_size;
  logic        store_push;
  logic        storefifo_full;
  logic        empty;
  logic [31:0] load_check_addr;
  logic        load_conflict;

  int tests = 0;
  int fails = 0;

  store_buffer_if mem_bus ();

  store_buffer #(.DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .store_addr      (store_addr),
    .store_val       (store_val),
    .store_size      (store_size),
    .store_push      (store_push),
    .storefifo_full  (storefifo_full),
    .empty           (empty),
    .mem             (mem_bus.master),
    .load_check_addr (load_check_addr),
    .load_conflict   (load_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] v, input logic [1:0] s);
    store_addr = a;
    store_val  = v;
    store_size = s;
    store_push = 1'b1;
  endtask

  initial begin
    reset           = 1'b0;
    store_addr      = '0;
    store_val       = '0;
    store_size      = '0;
    store_push      = 1'b0;
    load_check_addr = '0;
    mem_bus.mem_ack = 1'b0;

    tick();
    tick();
    chk("rst_full",     32'(storefifo_full),        32'd0);
    chk("rst_empty",    32'(empty),                 32'd1);
    chk("rst_req",      32'(mem_bus.mem_req),       32'd0);
    chk("rst_conflict", 32'(load_conflict),         32'd0);
    reset = 1'b1;
    tick();

    // Byte store at 0x1003 with constant ack.
    mem_bus.mem_ack = 1'b1;
    push(32'h0000_1003, 32'h0000_00AB, 2'd0);
    tick();
    store_push = 1'b0;
    chk("byte_req",   32'(mem_bus.mem_req), 32'd1);
    chk("byte_addr",  mem_bus.mem_addr,     32'h0000_1000);
    chk("byte_strb",  32'(mem_bus.mem_wstrb), 32'h8);
    chk("byte_wdata", mem_bus.mem_wdata,    32'hABAB_ABAB);
    tick();
    chk("byte_empty", 32'(empty),           32'd1);
    chk("byte_noreq", 32'(mem_bus.mem_req), 32'd0);

    // Fill with ack held low; slots used wrap 1,2,3,0.
    mem_bus.mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("fill_notfull", 32'(storefifo_full), 32'd0);
      push(32'h100 + 32'(4 * k), 32'h1111_0000 + 32'(k), 2'd2);
      tick();
    end
    chk("fill_full", 32'(storefifo_full), 32'd1);
    push(32'h0000_0200, 32'h0000_DEAD, 2'd2);
    tick();
    store_push = 1'b0;
    load_check_addr = 32'h0000_0200;
    #1;
    chk("fill_5th_full",     32'(storefifo_full), 32'd1);
    chk("fill_5th_conflict", 32'(load_conflict),  32'd0);
    load_check_addr = 32'h0000_010C;
    #1;
    chk("fill_tail_conflict", 32'(load_conflict), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("drain_addr",  mem_bus.mem_addr,      32'h100 + 32'(4 * k));
      chk("drain_wdata", mem_bus.mem_wdata,     32'h1111_0000 + 32'(k));
      chk("drain_strb",  32'(mem_bus.mem_wstrb), 32'hF);
      mem_bus.mem_ack = 1'b1;
      tick();
      mem_bus.mem_ack = 1'b0;
    end
    chk("drain_empty", 32'(empty), 32'd1);
    push(32'h0000_0300, 32'h0000_0055, 2'd2);
    tick();
    store_push = 1'b0;
    chk("after_wrap_addr",  mem_bus.mem_addr,  32'h0000_0300);
    chk("after_wrap_wdata", mem_bus.mem_wdata, 32'h0000_0055);
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    chk("after_wrap_empty", 32'(empty), 32'd1);

    // Full + push + ack in one cycle: pop happens, push is dropped.
    for (int k = 0; k < 4; k++) begin
      push(32'h400 + 32'(4 * k), 32'hA0 + 32'(k), 2'd2);
      tick();
    end
    store_push = 1'b0;
    chk("fp_full", 32'(storefifo_full), 32'd1);
    push(32'h0000_0500, 32'h0000_0077, 2'd2);
    mem_bus.mem_ack = 1'b1;
    tick();
    store_push = 1'b0;
    load_check_addr = 32'h0000_0500;
    #1;
    chk("fp_notfull",  32'(storefifo_full), 32'd0);
    chk("fp_head",     mem_bus.mem_addr,    32'h0000_0404);
    chk("fp_conflict", 32'(load_conflict),  32'd0);
    tick();
    chk("fp_head2", mem_bus.mem_addr, 32'h0000_0408);
    tick();
    chk("fp_head3", mem_bus.mem_addr, 32'h0000_040C);
    tick();
    chk("fp_empty", 32'(empty), 32'd1);

    // Half store and load hazard.
    mem_bus.mem_ack = 1'b0;
    push(32'h0000_2002, 32'h0000_1234, 2'd1);
    tick();
    store_push = 1'b0;
    chk("half_strb",  32'(mem_bus.mem_wstrb), 32'hC);
    chk("half_wdata", mem_bus.mem_wdata,      32'h1234_1234);
    load_check_addr = 32'h0000_2000;
    #1;
    chk("half_hit",  32'(load_conflict), 32'd1);
    load_check_addr = 32'h0000_2004;
    #1;
    chk("half_miss", 32'(load_conflict), 32'd0);
    mem_bus.mem_ack = 1'b1;
    load_check_addr = 32'h0000_2000;
    tick();
    chk("half_gone",  32'(load_conflict), 32'd0);
    chk("half_empty", 32'(empty),         32'd1);

    // Byte at lane 1, then reserved size drains with no strobes.
    mem_bus.mem_ack = 1'b0;
    push(32'h0000_3001, 32'h0000_00FF, 2'd0);
    tick();
    push(32'h0000_3004, 32'h0000_00FF, 2'd3);
    chk("byte1_strb",  32'(mem_bus.mem_wstrb), 32'h2);
    chk("byte1_wdata", mem_bus.mem_wdata,      32'hFFFF_FFFF);
    tick();
    store_push = 1'b0;
    mem_bus.mem_ack = 1'b1;
    tick();
    chk("rsv_strb", 32'(mem_bus.mem_wstrb), 32'h0);
    chk("rsv_addr", mem_bus.mem_addr,       32'h0000_3004);
    tick();
    chk("rsv_empty", 32'(empty), 32'd1);

    // Streaming: one push and one write per cycle.
    for (int i = 0; i < 10; i++) begin
      push(32'h6000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 2'd2);
      tick();
      chk("stream_req",   32'(mem_bus.mem_req),  32'd1);
      chk("stream_addr",  mem_bus.mem_addr,      32'h6000 + 32'(4 * i));
      chk("stream_wdata", mem_bus.mem_wdata,     32'hC0DE_0000 + 32'(i));
      chk("stream_full",  32'(storefifo_full),   32'd0);
    end
    store_push = 1'b0;
    tick();
    chk("stream_empty", 32'(empty), 32'd1);

    // Asynchronous reset mid-drain.
    mem_bus.mem_ack = 1'b0;
    push(32'h0000_7000, 32'h1, 2'd2);
    tick();
    push(32'h0000_7004, 32'h2, 2'd2);
    tick();
    store_push = 1'b0;
    chk("pre_rst_req", 32'(mem_bus.mem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_empty", 32'(empty),            32'd1);
    chk("arst_req",   32'(mem_bus.mem_req),  32'd0);
    chk("arst_full",  32'(storefifo_full),   32'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("post_rst_empty", 32'(empty),           32'd1);
    chk("post_rst_req",   32'(mem_bus.mem_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits directly downstream of the execute-stage store unit and buffers committed stores in a FIFO.
- Each store arrives as address, value and size. The head entry drains to the data-memory write port through a req/ack handshake.
- Produces the storefifo_full backpressure seen by execute, and a load-hazard flag for the load unit.
- Buffered stores are architecturally committed: pipeline flush never discards them.

Parameters:
- DEPTH, 4, number of store entries; must be a power of two and at least 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- store_addr  input  32  byte address of incoming store
- store_val  input  32  store data, right-aligned in bits [n:0]
- store_size  input  2  0=byte, 1=half, 2=word (3 reserved)
- store_push  input  1  enqueue request; equals execute valid && store_valid
- storefifo_full  output  1  buffer holds DEPTH entries
- empty  output  1  no entries pending (used by fence/drain logic)
- mem_req  output  1  head entry presented to memory
- mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata  output  32  lane-replicated write data
- mem_wstrb  output  4  byte-enable strobes
- mem_ack  input  1  memory accepted the current write
- load_check_addr  input  32  address of an in-flight load
- load_conflict  output  1  a pending store hits the same 32-bit word

Behaviour:
- Storage: DEPTH entries of {addr[31:0], val[31:0], size[1:0]}, plus head pointer, tail pointer and a count of width $clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Reset (reset==0, asynchronous): head=tail=count=0.
  - Outputs during reset: storefifo_full=0, empty=1, mem_req=0, load_conflict=0.
  - Reset mid-transaction drops all entries. Any outstanding mem_req is abandoned.
- Full/empty:
  - storefifo_full = (count==DEPTH), combinational from count.
  - empty = (count==0).
- Push: accepted when store_push && !storefifo_full. The entry is written at tail on that clk edge and tail advances.
  - Push while full is ignored with no state change; upstream must stall on storefifo_full.
  - A push is rejected while full even if a pop occurs in the same cycle. No full-bypass.
- Pop/drain:
  - mem_req = !empty. mem_addr, mem_wdata and mem_wstrb are driven from the head entry.
  - These outputs stay stable while mem_req && !mem_ack.
  - On mem_req && mem_ack the head advances on the clk edge; the next entry is presented the following cycle. This allows back-to-back one store per cycle with constant ack.
  - mem_ack while empty is ignored.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- Latency: a store pushed at edge N (into an empty buffer) drives mem_req=1 in the cycle after edge N. No bypass from store_* inputs to mem_*.
- Lane alignment (combinational, on the head entry):
  - Byte: wstrb = 4'b0001<<addr[1:0]; wdata = {4{val[7:0]}}.
  - Half: wstrb = 4'b0011<<{addr[1],1'b0}; wdata = {2{val[15:0]}}. addr[0] is ignored; misalignment is already excepted upstream.
  - Word: wstrb = 4'b1111; wdata = val.
  - Size 3: wstrb = 4'b0000 and the entry still drains. Never generated upstream.
- load_conflict (combinational): 1 if any valid entry, including the head currently in a transaction, has addr[31:2]==load_check_addr[31:2]. An entry counts as valid iff its index lies between head (inclusive) and tail (exclusive) with count accounted. It is 0 when empty.
  - A store pushed at edge N is visible to load_conflict from the cycle after edge N.
- No flush input. Flush handling lives entirely upstream.

Decomposition:
- Shared package store_pkg:
  - size encodings STORE_SIZE_BYTE=0, STORE_SIZE_HALF=1, STORE_SIZE_WORD=2
  - packed typedef store_entry_t {addr, val, size}
  - strobe constants
- One combinational sub-module, store_lane_align: inputs addr[1:0], size, val; outputs wdata and wstrb. It is reused later by the load/store forwarding path.

Test Plan:
- Reset low mid-drain (two entries, mem_ack held 0) -> immediately empty=1, mem_req=0; after release, still empty with no spurious mem_req.
- Push byte addr=0x1003 val=0xAB, mem_ack=1 -> next cycle mem_req=1, mem_addr=0x1000, mem_wstrb=4'b1000, mem_wdata=0xABABABAB; empty=1 one cycle later.
- Push DEPTH=4 words with mem_ack=0 -> storefifo_full=1 after the 4th edge; a 5th push is ignored. Then ack 4 times -> data drains in FIFO order with correct pointer wrap; a subsequent push works.
- Full buffer with store_push=1 and mem_ack=1 in the same cycle -> pop occurs, push rejected, count=3, storefifo_full=0 next cycle.
- Half store addr=0x2002 val=0x1234 pending -> load_check_addr=0x2000 gives load_conflict=1, 0x2004 gives 0; after the ack edge, 0x2000 gives 0.
- Constant mem_ack=1 with a push every cycle for 10 cycles -> one mem write per cycle; storefifo_full never asserts; addresses and values match push order.
